// File: rtl/fetch_queue_if.sv
// Fetch-stage signal bundle: instruction memory request/response, decode output and redirect.
// The fetch queue uses the master modport; the memory/decode environment uses slave.
interface fetch_queue_if #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
);
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [A_WIDTH-1:0] mem_req_addr;
  logic               mem_rsp_valid;
  logic [D_WIDTH-1:0] mem_rsp_data;
  logic               out_valid;
  logic               out_ready;
  logic [D_WIDTH-1:0] out_instr;
  logic [A_WIDTH-1:0] out_pc;
  logic               redirect;
  logic [A_WIDTH-1:0] redirect_pc;

  modport master (
    output mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited sequential fetch, in-order response FIFO, redirect flush.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_queue #(
  parameter int                 A_WIDTH  = 32,
  parameter int                 D_WIDTH  = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);

  localparam int                 PW      = $clog2(DEPTH);
  localparam int                 CW      = PW + 1;
  localparam logic [CW:0]        DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [A_WIDTH-1:0] STEP    = A_WIDTH'(4);

  logic [A_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [A_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      outstanding_q, outstanding_d;
  logic [CW-1:0]      discard_q, discard_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               started_q;

  logic [D_WIDTH-1:0] instr_mem [DEPTH];
  logic [A_WIDTH-1:0] pc_mem    [DEPTH];

  logic [A_WIDTH-1:0] redirect_target;
  logic [CW:0]        credits_used;
  logic               req_fire;
  logic               fifo_nonempty;
  logic               rsp_live;
  logic               bypass_hit;
  logic               bypass_take;
  logic               push;
  logic               pop;

  assign redirect_target = bus.redirect_pc & ~A_WIDTH'(3);

  // Every buffered entry and every in-flight request (stale or not) holds a credit.
  assign credits_used      = {1'b0, count_q} + {1'b0, outstanding_q};
  assign bus.mem_req_valid = started_q && (credits_used < DEPTH_C) && !bus.redirect;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;

  assign fifo_nonempty = (count_q != '0);
  assign rsp_live      = bus.mem_rsp_valid && !bus.redirect && (discard_q == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = rsp_live && !fifo_nonempty;
`else
  assign bypass_hit = 1'b0;
`endif

  assign bypass_take   = bypass_hit && bus.out_ready;
  assign push          = rsp_live && !bypass_take;
  assign pop           = fifo_nonempty && bus.out_ready && !bus.redirect;
  assign bus.out_valid = fifo_nonempty || bypass_hit;

  always_comb begin
    bus.out_instr = '0;
    bus.out_pc    = '0;
    if (fifo_nonempty) begin
      bus.out_instr = instr_mem[rd_ptr_q];
      bus.out_pc    = pc_mem[rd_ptr_q];
    end else if (bypass_hit) begin
      bus.out_instr = bus.mem_rsp_data;
      bus.out_pc    = rsp_pc_q;
    end
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (bus.redirect) begin
      // Requests already marked for discard are still inside outstanding, so
      // everything left in flight after this cycle's response becomes stale.
      fetch_pc_d    = redirect_target;
      rsp_pc_d      = redirect_target;
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      outstanding_d = outstanding_q - CW'(bus.mem_rsp_valid);
      discard_d     = outstanding_q - CW'(bus.mem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + STEP;
      end
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(bus.mem_rsp_valid);
      if (bus.mem_rsp_valid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CW'(1);
        end else begin
          rsp_pc_d = rsp_pc_q + STEP;
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      started_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      started_q     <= 1'b1;
    end
  end

  // Storage needs no reset: outputs are masked by count while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.mem_rsp_data;
      pc_mem[wr_ptr_q]    <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: randomized memory/decode stimulus scored against a
// request-list and instruction-queue model of the fetch stage.
module tb_fetch_queue;

  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] MAGIC    = 32'hA5A5_A5A5;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fetch_queue_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus ();

  fetch_queue #(
    .A_WIDTH (AW),
    .D_WIDTH (DW),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  int lat_min = 1, lat_max = 1;
  int ready_pct = 100, oready_pct = 100, redir_permille = 0;
  bit          redir_once = 1'b0;
  logic [31:0] redir_target = '0;

  logic [31:0] exp_fetch;
  req_t        memq[$];
  item_t       expq[$];
  logic [31:0] cons_log[$];
  logic [31:0] req_log[$];
  int          gaps;
  bit          seen_consume;
  bit          last_rv, last_ov;
  logic [31:0] last_addr;

  // Score one cycle of sampled handshakes against the model, then advance the model.
  task automatic observe();
    bit    exp_rv, exp_ov, live_rsp;
    item_t head;
    req_t  r;
    int    lat;
    live_rsp = bus.mem_rsp_valid && !bus.redirect && (memq.size() > 0) && !memq[0].stale;
    exp_rv   = ((expq.size() + memq.size()) < DEPTH) && !bus.redirect;
    exp_ov   = (expq.size() != 0);
`ifdef FETCH_BYPASS_EN
    if (live_rsp) exp_ov = 1'b1;
`endif
    checks++;
    if (bus.mem_req_valid !== exp_rv)
      $display("[TB] FAIL req_valid cyc=%0d got=%b exp=%b", cyc, bus.mem_req_valid, exp_rv);
    else passes++;
    checks++;
    if (bus.mem_req_addr !== exp_fetch)
      $display("[TB] FAIL req_addr cyc=%0d got=%h exp=%h", cyc, bus.mem_req_addr, exp_fetch);
    else passes++;
    checks++;
    if (bus.out_valid !== exp_ov)
      $display("[TB] FAIL out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, exp_ov);
    else passes++;
    if (exp_ov) begin
      if (expq.size() != 0) head = expq[0];
      else head = '{memq[0].addr, memq[0].addr ^ MAGIC};
      checks++;
      if (bus.out_pc !== head.pc || bus.out_instr !== head.instr)
        $display("[TB] FAIL out_head cyc=%0d got=%h/%h exp=%h/%h", cyc,
                 bus.out_pc, bus.out_instr, head.pc, head.instr);
      else passes++;
    end

    if (bus.mem_rsp_valid) begin
      r = memq.pop_front();
      if (!bus.redirect && !r.stale) expq.push_back('{r.addr, r.addr ^ MAGIC});
    end
    if (exp_ov && bus.out_ready && !bus.redirect) begin
      head = expq.pop_front();
      cons_log.push_back(head.pc);
      seen_consume = 1'b1;
    end else if (seen_consume) begin
      gaps++;
    end
    checks++;
    if (expq.size() > DEPTH)
      $display("[TB] FAIL overflow cyc=%0d got=%0d exp<=%0d", cyc, expq.size(), DEPTH);
    else passes++;

    if (bus.mem_req_valid && bus.mem_req_ready) begin
      lat = int'($urandom_range(lat_max, lat_min));
      memq.push_back('{bus.mem_req_addr, cyc + lat, bus.redirect});
      req_log.push_back(bus.mem_req_addr);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (bus.redirect) begin
      foreach (memq[i]) memq[i].stale = 1'b1;
      expq.delete();
      cons_log.delete();
      req_log.delete();
      seen_consume = 1'b0;
      exp_fetch = bus.redirect_pc & ~32'h3;
    end
    last_rv   = bus.mem_req_valid;
    last_ov   = bus.out_valid;
    last_addr = bus.mem_req_addr;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = memq[0].addr ^ MAGIC;
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
    end
    bus.mem_req_ready = (int'($urandom_range(99)) < ready_pct);
    bus.out_ready     = (int'($urandom_range(99)) < oready_pct);
    if (redir_once) begin
      bus.redirect    = 1'b1;
      bus.redirect_pc = redir_target;
      redir_once      = 1'b0;
    end else begin
      bus.redirect    = (int'($urandom_range(999)) < redir_permille);
      bus.redirect_pc = $urandom;
    end
    @(negedge clk);
    observe();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.out_ready     = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_pc   = '0;
    memq.delete();
    expq.delete();
    cons_log.delete();
    req_log.delete();
    gaps = 0;
    seen_consume = 1'b0;
    exp_fetch = RESET_PC;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_req_valid !== 1'b0)
      $display("[TB] FAIL release_req_valid got=%b exp=0", bus.mem_req_valid);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.out_ready     = 1'b1;
    bus.redirect      = 1'b0;
    bus.redirect_pc   = '0;
    #12;
    checks++;
    if (bus.mem_req_valid !== 1'b0) $display("[TB] FAIL rst_req_valid got=%b exp=0", bus.mem_req_valid);
    else passes++;
    checks++;
    if (bus.out_valid !== 1'b0) $display("[TB] FAIL rst_out_valid got=%b exp=0", bus.out_valid);
    else passes++;
    checks++;
    if (bus.out_instr !== '0 || bus.out_pc !== '0)
      $display("[TB] FAIL rst_out_data got=%h/%h exp=0/0", bus.out_instr, bus.out_pc);
    else passes++;
    checks++;
    if (bus.mem_req_addr !== RESET_PC)
      $display("[TB] FAIL rst_req_addr got=%h exp=%h", bus.mem_req_addr, RESET_PC);
    else passes++;
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    lat_min = 1; lat_max = 1; ready_pct = 100; oready_pct = 100; redir_permille = 0;
    run(24);
    checks++;
    if (cons_log.size() < 3 || cons_log[0] !== 32'h0 || cons_log[1] !== 32'h4 || cons_log[2] !== 32'h8)
      $display("[TB] FAIL stream_order got_count=%0d exp first pcs 0,4,8", cons_log.size());
    else passes++;
    checks++;
    if (cons_log.size() < 20) $display("[TB] FAIL stream_rate got=%0d exp>=20", cons_log.size());
    else passes++;
    checks++;
    if (gaps != 0) $display("[TB] FAIL stream_gaps got=%0d exp=0", gaps);
    else passes++;
  endtask

  task automatic test_backpressure();
    do_reset();
    lat_min = 1; lat_max = 1; ready_pct = 100; oready_pct = 0; redir_permille = 0;
    run(8);
    checks++;
    if (req_log.size() != DEPTH || req_log[DEPTH-1] !== 32'hC || last_rv !== 1'b0)
      $display("[TB] FAIL bp_fill got=%0d reqs rv=%b exp=4 reqs rv=0", req_log.size(), last_rv);
    else passes++;
    oready_pct = 100;
    cycle();
    oready_pct = 0;
    cycle();
    checks++;
    if (req_log.size() != DEPTH + 1 || last_addr !== 32'h10 || last_rv !== 1'b1)
      $display("[TB] FAIL bp_refill got=%0d reqs addr=%h exp=5 reqs addr=10", req_log.size(), last_addr);
    else passes++;
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    lat_min = 4; lat_max = 4; ready_pct = 100; oready_pct = 100; redir_permille = 0;
    run(3);
    redir_once = 1'b1;
    redir_target = 32'h0000_0103;
    cycle();
    cycle();
    checks++;
    if (last_rv !== 1'b1 || last_addr !== 32'h100 || last_ov !== 1'b0)
      $display("[TB] FAIL redir_next got=rv%b/%h/ov%b exp=rv1/100/ov0", last_rv, last_addr, last_ov);
    else passes++;
    run(12);
    checks++;
    if (cons_log.size() == 0 || cons_log[0] !== 32'h100)
      $display("[TB] FAIL redir_first_pc got_count=%0d exp first pc 100", cons_log.size());
    else passes++;
  endtask

  task automatic test_redirect_pop();
    bit hit = 1'b0;
    do_reset();
    lat_min = 2; lat_max = 2; ready_pct = 100; oready_pct = 0; redir_permille = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (expq.size() == 2 && memq.size() > 0 && memq[0].due <= cyc + 1) begin
        hit = 1'b1;
        redir_once = 1'b1;
        redir_target = 32'h0000_0200;
        oready_pct = 100;
      end
      cycle();
    end
    checks++;
    if (!hit) $display("[TB] FAIL rp_setup got=timeout exp=count2 with response");
    else passes++;
    cycle();
    checks++;
    if (last_ov !== 1'b0) $display("[TB] FAIL rp_flush got=%b exp=0", last_ov);
    else passes++;
    run(12);
    checks++;
    if (cons_log.size() == 0 || cons_log[0] !== 32'h200)
      $display("[TB] FAIL rp_first_pc got_count=%0d exp first pc 200", cons_log.size());
    else passes++;
  endtask

  task automatic test_wrap();
    do_reset();
    lat_min = 1; lat_max = 1; ready_pct = 100; oready_pct = 100; redir_permille = 0;
    redir_once = 1'b1;
    redir_target = 32'hFFFF_FFFC;
    cycle();
    run(10);
    checks++;
    if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0)
      $display("[TB] FAIL wrap_fetch got_count=%0d exp FFFFFFFC then 0", req_log.size());
    else passes++;
    checks++;
    if (cons_log.size() < 2 || cons_log[0] !== 32'hFFFF_FFFC || cons_log[1] !== 32'h0)
      $display("[TB] FAIL wrap_out got_count=%0d exp FFFFFFFC then 0", cons_log.size());
    else passes++;
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 1; lat_max = 3; ready_pct = 70; oready_pct = 60; redir_permille = 40;
    run(400);
    redir_permille = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    lat_min = 1; lat_max = 1; ready_pct = 100; oready_pct = 0; redir_permille = 0;
    run(8);
    checks++;
    if (bus.out_valid !== 1'b1 || expq.size() != DEPTH)
      $display("[TB] FAIL ar_full got=ov%b/%0d exp=ov1/%0d", bus.out_valid, expq.size(), DEPTH);
    else passes++;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.mem_req_valid !== 1'b0 || bus.out_valid !== 1'b0)
      $display("[TB] FAIL ar_valids got=rv%b/ov%b exp=0/0", bus.mem_req_valid, bus.out_valid);
    else passes++;
    checks++;
    if (bus.out_pc !== '0 || bus.out_instr !== '0 || bus.mem_req_addr !== RESET_PC)
      $display("[TB] FAIL ar_data got=%h/%h/%h exp=0/0/%h", bus.out_pc, bus.out_instr,
               bus.mem_req_addr, RESET_PC);
    else passes++;
    do_reset();
    oready_pct = 100;
    run(4);
    checks++;
    if (req_log.size() == 0 || req_log[0] !== RESET_PC)
      $display("[TB] FAIL ar_restart got_count=%0d exp first req %h", req_log.size(), RESET_PC);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_pop();
    test_wrap();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
